// File: rtl/d_kes_sminodr_iter_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// d_kes_sminodr_iter_ctrl : BM iteration sequencer for the sMINodr PE_ELU array
// Revision 1.0
// ---------------------------------------------------------------------------
module d_kes_sminodr_iter_ctrl #(
  parameter int T        = 14,
  parameter int GF_ORDER = 12,
  parameter int DC_LAT   = 1,
  parameter int KW       = 5,
  localparam int ITW     = (T > 1) ? $clog2(T) : 1
) (
  input  logic                i_clk,
  input  logic                i_RESET_KES,
  input  logic                i_stop_dec,
  input  logic                i_start,
  input  logic [GF_ORDER-1:0] i_d_2i,
  output logic                o_ready,
  output logic                o_EXECUTE_PE_DC,
  output logic                o_EXECUTE_PE_ELU,
  output logic [GF_ORDER-1:0] o_d_2i,
  output logic [GF_ORDER-1:0] o_delta_2im2,
  output logic                o_condition_2i,
  output logic [ITW-1:0]      o_iter_cnt,
  output logic                o_done
);

  localparam int WCW = (DC_LAT > 1) ? $clog2(DC_LAT) : 1;

  localparam logic [5:0] S_IDLE = 6'b000001;
  localparam logic [5:0] S_DC   = 6'b000010;
  localparam logic [5:0] S_WAIT = 6'b000100;
  localparam logic [5:0] S_ELU  = 6'b001000;
  localparam logic [5:0] S_UPD  = 6'b010000;
  localparam logic [5:0] S_DONE = 6'b100000;

  logic [5:0]          state;
  logic [WCW-1:0]      wcnt;
  logic [ITW-1:0]      iter;
  logic [KW-1:0]       k;
  logic [GF_ORDER-1:0] d_2i;
  logic [GF_ORDER-1:0] delta;
  logic                cond;

  always_ff @(posedge i_clk or posedge i_RESET_KES) begin
    if (i_RESET_KES) begin
      state <= S_IDLE;
      wcnt  <= '0;
      iter  <= '0;
      k     <= '0;
      d_2i  <= '0;
      delta <= GF_ORDER'(1);
      cond  <= 1'b0;
    end else if (i_stop_dec) begin
      state <= S_IDLE;
      wcnt  <= '0;
      iter  <= '0;
      k     <= '0;
      d_2i  <= '0;
      delta <= GF_ORDER'(1);
      cond  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (i_start) begin
            state <= S_DC;
            iter  <= '0;
            k     <= '0;
            delta <= GF_ORDER'(1);
          end
        end
        S_DC: begin
          wcnt  <= WCW'(DC_LAT - 1);
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (wcnt == '0) begin
            d_2i  <= i_d_2i;
            // k >= 0 is simply a clear sign bit
            cond  <= (i_d_2i != '0) && !k[KW-1];
            state <= S_ELU;
          end else begin
            wcnt <= wcnt - WCW'(1);
          end
        end
        S_ELU: begin
          state <= S_UPD;
        end
        S_UPD: begin
          // -k-1 in two's complement is the bitwise inverse
          if (cond) begin
            delta <= d_2i;
            k     <= ~k;
          end else begin
            k <= k + KW'(1);
          end
          if (iter == ITW'(T - 1)) begin
            state <= S_DONE;
          end else begin
            iter  <= iter + ITW'(1);
            state <= S_DC;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  assign o_ready          = state[0];
  assign o_EXECUTE_PE_DC  = state[1];
  assign o_EXECUTE_PE_ELU = state[3];
  assign o_done           = state[5];
  assign o_d_2i           = d_2i;
  assign o_delta_2im2     = delta;
  assign o_condition_2i   = cond;
  assign o_iter_cnt       = iter;

endmodule
`default_nettype wire

// File: tb/tb_d_kes_sminodr_iter_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_d_kes_sminodr_iter_ctrl : directed bench, T=4 with DC_LAT=1 and DC_LAT=3
// Revision 1.0
// ---------------------------------------------------------------------------
module tb_d_kes_sminodr_iter_ctrl;

  typedef struct {
    logic [11:0] d;
    logic [11:0] delta;
    logic        cond;
    logic [1:0]  iter;
    logic [4:0]  k;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst, stop_in, start_a, start_b;
  logic [11:0] d_in;
  logic sel;

  logic rdy_a, dc_a, elu_a, cond_a, done_a;
  logic [11:0] d_a, delta_a;
  logic [1:0] iter_a;
  logic rdy_b, dc_b, elu_b, cond_b, done_b;
  logic [11:0] d_b, delta_b;
  logic [1:0] iter_b;

  logic obs_ready, obs_dc, obs_elu, obs_cond, obs_done;
  logic [11:0] obs_d, obs_delta;
  logic [1:0] obs_iter;
  logic [4:0] obs_k;

  int n_assert = 0;
  int n_fail = 0;
  exp_t sb[$];
  logic [11:0] seq [4];

  always #5 clk = ~clk;

  d_kes_sminodr_iter_ctrl #(.T(4), .GF_ORDER(12), .DC_LAT(1), .KW(5)) dut_a (
    .i_clk(clk), .i_RESET_KES(rst), .i_stop_dec(stop_in), .i_start(start_a), .i_d_2i(d_in),
    .o_ready(rdy_a), .o_EXECUTE_PE_DC(dc_a), .o_EXECUTE_PE_ELU(elu_a), .o_d_2i(d_a),
    .o_delta_2im2(delta_a), .o_condition_2i(cond_a), .o_iter_cnt(iter_a), .o_done(done_a)
  );

  d_kes_sminodr_iter_ctrl #(.T(4), .GF_ORDER(12), .DC_LAT(3), .KW(5)) dut_b (
    .i_clk(clk), .i_RESET_KES(rst), .i_stop_dec(stop_in), .i_start(start_b), .i_d_2i(d_in),
    .o_ready(rdy_b), .o_EXECUTE_PE_DC(dc_b), .o_EXECUTE_PE_ELU(elu_b), .o_d_2i(d_b),
    .o_delta_2im2(delta_b), .o_condition_2i(cond_b), .o_iter_cnt(iter_b), .o_done(done_b)
  );

  assign obs_ready = sel ? rdy_b   : rdy_a;
  assign obs_dc    = sel ? dc_b    : dc_a;
  assign obs_elu   = sel ? elu_b   : elu_a;
  assign obs_cond  = sel ? cond_b  : cond_a;
  assign obs_done  = sel ? done_b  : done_a;
  assign obs_d     = sel ? d_b     : d_a;
  assign obs_delta = sel ? delta_b : delta_a;
  assign obs_iter  = sel ? iter_b  : iter_a;
  assign obs_k     = sel ? dut_b.k : dut_a.k;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_vals(input string tag);
    chk({tag, "_ready"}, 32'(obs_ready), 1);
    chk({tag, "_dc"},    32'(obs_dc), 0);
    chk({tag, "_elu"},   32'(obs_elu), 0);
    chk({tag, "_done"},  32'(obs_done), 0);
    chk({tag, "_d"},     32'(obs_d), 0);
    chk({tag, "_delta"}, 32'(obs_delta), 1);
    chk({tag, "_cond"},  32'(obs_cond), 0);
    chk({tag, "_iter"},  32'(obs_iter), 0);
    chk({tag, "_k"},     32'(obs_k), 0);
  endtask

  // One codeword on the selected DUT; the model fills the scoreboard up front
  task automatic run(input bit s, input int abort_at, input int restart_at,
                     input int exp_ndc, input int exp_nelu);
    int L, budget, dcc, ndc, nelu, ndone, km;
    logic [11:0] dm;
    exp_t e;
    L = s ? 3 : 1;
    budget = 4 * (L + 3) + 4;
    dm = 12'd1;
    km = 0;
    sb.delete();
    for (int i = 0; i < 4; i++) begin
      e.d = seq[i];
      e.delta = dm;
      e.k = km[4:0];
      e.iter = 2'(i);
      e.cond = (seq[i] != 12'd0) && (km >= 0);
      e.cyc = 1 + i * (L + 3) + L + 1;
      sb.push_back(e);
      if (e.cond) begin
        dm = seq[i];
        km = -km - 1;
      end else begin
        km = km + 1;
      end
    end
    sel = s;
    ndc = 0; nelu = 0; ndone = 0; dcc = -100;
    if (s) start_b = 1'b1; else start_a = 1'b1;
    tick();
    for (int cyc = 1; cyc <= budget; cyc++) begin
      d_in = 12'hFFF;
      stop_in = 1'b0;
      start_a = 1'b0;
      start_b = 1'b0;
      if (obs_dc) begin
        ndc++;
        dcc = cyc;
        chk("dc_cycle", cyc, 1 + (ndc - 1) * (L + 3));
      end
      if (cyc == dcc + L) d_in = seq[ndc-1];
      if (obs_elu) begin
        nelu++;
        chk("elu_queue_nonempty", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("elu_cycle", cyc, e.cyc);
          chk("elu_d", 32'(obs_d), 32'(e.d));
          chk("elu_delta", 32'(obs_delta), 32'(e.delta));
          chk("elu_cond", 32'(obs_cond), 32'(e.cond));
          chk("elu_iter", 32'(obs_iter), 32'(e.iter));
          chk("elu_k", 32'(obs_k), 32'(e.k));
        end
      end
      if (obs_done) begin
        ndone++;
        chk("done_cycle", cyc, 4 * (L + 3) + 1);
        chk("k_final", 32'(obs_k), 32'(km[4:0]));
        chk("delta_final", 32'(obs_delta), 32'(dm));
        tick();
        chk("ready_after_done", 32'(obs_ready), 1);
        chk("done_one_cycle", 32'(obs_done), 0);
        break;
      end
      if (abort_at > 0 && cyc == abort_at + 1) chk_idle_vals("abort");
      if (cyc == restart_at) begin
        if (s) start_b = 1'b1; else start_a = 1'b1;
      end
      if (cyc == abort_at) begin
        stop_in = 1'b1;
        sb.delete();
      end
      tick();
    end
    start_a = 1'b0;
    start_b = 1'b0;
    stop_in = 1'b0;
    chk("dc_count", ndc, exp_ndc);
    chk("elu_count", nelu, exp_nelu);
    chk("done_count", ndone, (abort_at > 0) ? 0 : 1);
    chk("queue_empty", sb.size(), 0);
  endtask

  initial begin
    rst = 1'b1; stop_in = 1'b0; start_a = 1'b0; start_b = 1'b0;
    d_in = 12'd0; sel = 1'b0;
    tick();
    tick();
    chk_idle_vals("rst_a");
    sel = 1'b1;
    chk_idle_vals("rst_b");
    sel = 1'b0;
    rst = 1'b0;
    tick();

    // async reset in the middle of an ELU cycle
    d_in = 12'hFFF;
    start_a = 1'b1;
    tick();
    start_a = 1'b0;
    for (int i = 0; i < 10 && !obs_elu; i++) tick();
    chk("t1_reached_elu", 32'(obs_elu), 1);
    #2 rst = 1'b1;
    #1;
    chk_idle_vals("async_rst");
    #1 rst = 1'b0;
    tick();
    chk("t1_stays_idle", 32'(obs_ready), 1);

    // all-zero discrepancies
    seq = '{12'h000, 12'h000, 12'h000, 12'h000};
    run(1'b0, -1, -1, 4, 4);

    // mixed discrepancies
    seq = '{12'h0A3, 12'h5F0, 12'h001, 12'h000};
    run(1'b0, -1, -1, 4, 4);

    // abort during the second WAIT, then a clean codeword
    run(1'b0, 6, -1, 2, 1);
    run(1'b0, -1, -1, 4, 4);

    // start re-pulsed while busy
    seq = '{12'h7FF, 12'h000, 12'h123, 12'h800};
    run(1'b0, -1, 7, 4, 4);

    // start together with stop stays idle
    start_a = 1'b1;
    stop_in = 1'b1;
    tick();
    start_a = 1'b0;
    stop_in = 1'b0;
    chk("start_stop_ready", 32'(obs_ready), 1);
    tick();
    chk("start_stop_no_dc", 32'(obs_dc), 0);
    chk("start_stop_ready2", 32'(obs_ready), 1);

    // longer DC latency
    seq = '{12'h0A3, 12'h5F0, 12'h001, 12'h000};
    run(1'b1, -1, -1, 4, 4);
    seq = '{12'h000, 12'hABC, 12'h000, 12'h010};
    run(1'b1, -1, 5, 4, 4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
